// File: rtl/adc_capture.sv
// adc_capture: triggered snapshot buffer for an 8-bit ADC sample stream, configured and read over APB
module adc_capture #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic [7:0]  in,
  input  logic        valid_in,
  output logic        done,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] BUF_LO = 32'h1000;
  localparam logic [31:0] BUF_HI = 32'h1000 + 32'(4 * DEPTH);
  localparam logic [AW:0] DEP = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
  state_t state;
  logic [1:0] mode;
  logic signed [7:0] level, prev;
  logic [AW-1:0] pretrig, trig_addr, wp, start, idx;
  logic [AW:0] cnt, post_len;
  logic forced, force_pend, prev_valid;
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_q;
  logic wr, wr_ctrl, arm, abort, frc, stb, rise, fall, hit, trig, is_buf;
  logic [31:0] off, reg_rd;
  logic unused_bits;
  assign wr = psel && penable && pwrite;
  assign wr_ctrl = wr && paddr == 32'h0;
  assign abort = wr_ctrl && pwdata[1];
  assign arm = wr_ctrl && pwdata[0] && !pwdata[1];
  assign frc = wr_ctrl && pwdata[2];
  assign stb = valid_in && (state == FILL || state == ARMED || state == POST);
  assign rise = prev_valid && prev < level && $signed(in) >= level;
  assign fall = prev_valid && prev > level && $signed(in) <= level;
  assign hit = force_pend || (mode == 2'd1 ? rise : mode == 2'd2 ? fall : 1'b1);
  assign trig = state == ARMED && valid_in && hit;
  assign post_len = DEP - {1'b0, pretrig};
  assign start = trig_addr - pretrig;
  assign off = paddr - BUF_LO;
  assign idx = start + off[AW+1:2];
  assign done = state == DONE;
  assign is_buf = paddr >= BUF_LO && paddr < BUF_HI && paddr[1:0] == 2'b00;
  assign unused_bits = ^{pwdata, off};
  // Control registers, write pointer, trigger detection and capture state machine
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mode <= '0;
      level <= '0;
      pretrig <= '0;
      trig_addr <= '0;
      wp <= '0;
      cnt <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      forced <= 1'b0;
      force_pend <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (wr_ctrl) mode <= pwdata[9:8];
      if (wr && paddr == 32'h4) level <= pwdata[7:0];
      if (wr && paddr == 32'h8) pretrig <= pwdata[AW-1:0];
      if (stb) begin
        wp <= wp + 1'b1;
        prev <= in;
        prev_valid <= 1'b1;
      end
      if (frc && state == ARMED) force_pend <= 1'b1;
      if (abort) begin
        state <= IDLE;
        force_pend <= 1'b0;
      end else if (arm && (state == IDLE || state == DONE)) begin
        state <= pretrig != '0 ? FILL : ARMED;
        cnt <= '0;
        wp <= '0;
        prev_valid <= 1'b0;
        forced <= 1'b0;
        force_pend <= 1'b0;
      end else if (stb && state == FILL) begin
        cnt <= cnt + 1'b1 == {1'b0, pretrig} ? '0 : cnt + 1'b1;
        if (cnt + 1'b1 == {1'b0, pretrig}) state <= ARMED;
      end else if (trig) begin
        trig_addr <= wp;
        forced <= force_pend;
        force_pend <= 1'b0;
        cnt <= ONE;
        state <= post_len == ONE ? DONE : POST;
        irq <= post_len == ONE;
      end else if (stb && state == POST) begin
        cnt <= cnt + 1'b1;
        if (cnt + 1'b1 == post_len) begin
          state <= DONE;
          irq <= 1'b1;
        end
      end
    end
  // Sample RAM: write at the current pointer, read address captured in the APB setup phase
  always_ff @(posedge clk) begin
    if (stb) mem[wp] <= in;
    if (psel && !penable) rd_q <= mem[idx];
  end
  assign reg_rd = paddr == 32'h00 ? {22'd0, mode, 8'd0} :
                  paddr == 32'h04 ? {24'd0, level} :
                  paddr == 32'h08 ? 32'(pretrig) :
                  paddr == 32'h0C ? {23'd0, forced, 5'd0, state} :
                  paddr == 32'h10 ? 32'(trig_addr) :
                  paddr == 32'h14 ? 32'(start) :
                  is_buf ? {{24{rd_q[7]}}, rd_q} : 32'd0;
  assign prdata = psel && penable && !pwrite ? reg_rd : 32'd0;
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed checks of the triggered capture buffer at DEPTH=16
module tb_adc_capture;
  logic clk = 1'b0, reset_n = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0, valid_in = 1'b0;
  logic done, irq;
  logic [31:0] paddr = '0, pwdata = '0, prdata, d;
  logic [7:0] smp_in = '0;
  int n_cmp = 0, n_err = 0, irq_cnt = 0, irq_mark = 0;

  adc_capture #(.DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .in(smp_in), .valid_in(valid_in),
    .done(done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (irq === 1'b1) irq_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1;
    #1 v = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] v;
    apb_rd(a, v);
    chk(tag, v, e);
  endtask

  task automatic smp(input logic [7:0] v);
    @(negedge clk); smp_in = v; valid_in = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk); valid_in = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd_chk("rst_ctrl", 32'h00, 32'd0);
    rd_chk("rst_level", 32'h04, 32'd0);
    rd_chk("rst_pretrig", 32'h08, 32'd0);
    rd_chk("rst_status", 32'h0C, 32'd0);
    rd_chk("rst_trig", 32'h10, 32'd0);
    rd_chk("rst_start", 32'h14, 32'd0);
    rd_chk("unmapped", 32'h18, 32'd0);

    // rising edge through 0 on a ramp, 4 pre-trigger samples
    apb_wr(32'h08, 32'hFFF4);
    rd_chk("pretrig_mask", 32'h08, 32'd4);
    apb_wr(32'h04, 32'd0);
    irq_mark = irq_cnt;
    apb_wr(32'h00, 32'h101);
    rd_chk("t1_fill", 32'h0C, 32'd1);
    for (int v = -20; v <= 20; v++) smp(8'(v));
    idle();
    rd_chk("t1_status", 32'h0C, 32'd4);
    rd_chk("t1_trig", 32'h10, 32'd4);
    rd_chk("t1_start", 32'h14, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_irqs", 32'(irq_cnt - irq_mark), 32'd1);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("t1_buf%0d", i), 32'h1000 + 32'(4 * i), 32'(-4 + i));

    // immediate mode, no pre-trigger, strobe every other cycle
    apb_wr(32'h08, 32'd0);
    irq_mark = irq_cnt;
    apb_wr(32'h00, 32'h001);
    rd_chk("t2_armed", 32'h0C, 32'd2);
    chk("t2_done_low", {31'd0, done}, 32'd0);
    for (int k = 0; k < 15; k++) begin
      smp(8'(30 + k));
      idle();
    end
    rd_chk("t2_post15", 32'h0C, 32'd3);
    smp(8'd45);
    idle();
    rd_chk("t2_done16", 32'h0C, 32'd4);
    chk("t2_irqs", 32'(irq_cnt - irq_mark), 32'd1);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("t2_buf%0d", i), 32'h1000 + 32'(4 * i), 32'(30 + i));

    // falling mode never fires on flat input; FORCE does
    apb_wr(32'h08, 32'd4);
    apb_wr(32'h04, 32'd10);
    apb_wr(32'h00, 32'h201);
    rd_chk("t3_ctrl", 32'h00, 32'h200);
    rd_chk("t3_level", 32'h04, 32'd10);
    for (int k = 0; k < 24; k++) smp(8'd5);
    idle();
    rd_chk("t3_armed", 32'h0C, 32'd2);
    apb_wr(32'h00, 32'h201);
    rd_chk("t3_rearm", 32'h0C, 32'd2);
    apb_wr(32'h00, 32'h204);
    for (int k = 0; k < 12; k++) smp(8'(100 + k));
    idle();
    rd_chk("t3_status", 32'h0C, 32'h104);
    rd_chk("t3_trig", 32'h10, 32'd8);
    rd_chk("t3_start", 32'h14, 32'd4);
    rd_chk("t3_buf3", 32'h100C, 32'd5);
    rd_chk("t3_buf4", 32'h1010, 32'd100);
    rd_chk("t3_buf15", 32'h103C, 32'd111);

    // maximum pre-trigger: DONE on the trigger edge
    apb_wr(32'h08, 32'd15);
    apb_wr(32'h00, 32'h001);
    for (int k = 0; k < 15; k++) smp(8'(50 + k));
    smp(8'd65);
    idle();
    #1;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_irq_hi", {31'd0, irq}, 32'd1);
    idle();
    #1;
    chk("t4_irq_lo", {31'd0, irq}, 32'd0);
    rd_chk("t4_status", 32'h0C, 32'd4);
    rd_chk("t4_trig", 32'h10, 32'd15);
    rd_chk("t4_start", 32'h14, 32'd0);
    rd_chk("t4_buf0", 32'h1000, 32'd50);
    rd_chk("t4_buf15", 32'h103C, 32'd65);

    // abort during POST, then ARM+ABORT together
    apb_wr(32'h08, 32'd2);
    irq_mark = irq_cnt;
    apb_wr(32'h00, 32'h001);
    for (int k = 0; k < 5; k++) smp(8'(10 + k));
    idle();
    rd_chk("t5_post", 32'h0C, 32'd3);
    apb_wr(32'h00, 32'h002);
    rd_chk("t5_abort", 32'h0C, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    rd_chk("t5_trig", 32'h10, 32'd2);
    repeat (4) idle();
    chk("t5_irqs", 32'(irq_cnt - irq_mark), 32'd0);
    apb_wr(32'h00, 32'h003);
    rd_chk("t5_armabort", 32'h0C, 32'd0);

    // asynchronous reset in the middle of POST
    apb_wr(32'h08, 32'd3);
    apb_wr(32'h00, 32'h001);
    for (int k = 0; k < 6; k++) smp(8'(20 + k));
    idle();
    rd_chk("t6_post", 32'h0C, 32'd3);
    rd_chk("t6_trig_pre", 32'h10, 32'd3);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_irq", {31'd0, irq}, 32'd0);
    chk("t6_prdata", prdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("t6_status", 32'h0C, 32'd0);
    rd_chk("t6_pretrig", 32'h08, 32'd0);
    rd_chk("t6_trig", 32'h10, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
